// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// One operand bit pair is consumed per RUN cycle; the full difference and
// final borrow are published on the edge that enters DONE and held until
// the next result replaces them.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    // The result register only needs the WIDTH-1 already-computed bits; the
    // final bit joins them combinationally on the DONE-entry edge.
    localparam int RES_W = (WIDTH > 1) ? (WIDTH - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_a_s;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic [RES_W-1:0]        r_res;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_br;
    logic                    r_busy;
    logic                    r_done;
    logic [WIDTH-1:0]        r_diff;
    logic                    r_borrow;

    logic                    w_d;
    logic                    w_br_next;
    logic [WIDTH-1:0]        w_res_next;

    // One-bit full subtractor; returns {borrow_next, difference}.
    function automatic logic [1:0] sub_bit(input logic a0, input logic b0, input logic br);
        logic d;
        logic br_n;
        d    = a0 ^ b0 ^ br;
        br_n = (~a0 & b0) | (~(a0 ^ b0) & br);
        return {br_n, d};
    endfunction

    // Current bit of the subtraction from the operand LSBs and the borrow flop.
    always_comb begin
        {w_br_next, w_d} = sub_bit(r_a[0], r_b[0], r_br);
    end

    // Result with the current bit shifted in from the MSB side.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res};
        end
    endgenerate

    // Control FSM and bit-serial datapath, outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next[WIDTH-1 -: RES_W];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_br_next;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Signed view of the minuend is not needed; keep operands unsigned.
    assign r_a_s = '0;

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// at WIDTH = 8 (main instance), plus WIDTH = 1 and WIDTH = 32 instances.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  diff;
    logic        borrow_out;

    logic        s1_start;
    logic [0:0]  s1_a;
    logic [0:0]  s1_b;
    logic        s1_busy;
    logic        s1_done;
    logic [0:0]  s1_diff;
    logic        s1_borrow;

    logic        s32_start;
    logic [31:0] s32_a;
    logic [31:0] s32_b;
    logic        s32_busy;
    logic        s32_done;
    logic [31:0] s32_diff;
    logic        s32_borrow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .borrow_out(s1_borrow)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32_start), .a(s32_a), .b(s32_b),
        .busy(s32_busy), .done(s32_done), .diff(s32_diff), .borrow_out(s32_borrow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle on the WIDTH=8 instance and wait for done.
    // cyc = edges after the accepting edge until done seen; bcnt = busy cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          output int cyc, output int bcnt);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        bcnt  = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h01;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h expected 00", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow_out); end
        checks++; if (s32_diff !== 32'h0) begin errors++; $display("FAIL reset_diff32: got %h expected 0", s32_diff); end
        checks++; if (s1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", s1_busy); end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int cyc;
        int bcnt;
        run_op(8'h05, 8'h03, cyc, bcnt);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", cyc); end
        checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt); end
        checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff: got %h expected 02", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", borrow_out); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (diff !== 8'h02) begin errors++; $display("FAIL basic_diff_hold: got %h expected 02", diff); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_borrow();
        logic [7:0] va [3] = '{8'h03, 8'h00, 8'hFF};
        logic [7:0] vb [3] = '{8'h05, 8'h01, 8'hFF};
        logic [7:0] ed [3] = '{8'hFE, 8'hFF, 8'h00};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        int cyc;
        int bcnt;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], cyc, bcnt);
            checks++; if (diff !== ed[i]) begin errors++; $display("FAIL borrow_diff[%0d]: got %h expected %h", i, diff, ed[i]); end
            checks++; if (borrow_out !== eb[i]) begin errors++; $display("FAIL borrow_flag[%0d]: got %b expected %b", i, borrow_out, eb[i]); end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int   bcnt;
        int   dcnt;
        logic [7:0] got_d;
        logic got_b;
        got_d = 8'hxx;
        got_b = 1'bx;
        a     = 8'h80;
        b     = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcnt  = (busy === 1'b1) ? 1 : 0;
        dcnt  = 0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        tick();
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bcnt  = bcnt + 3;
        for (int i = 0; i < 27; i++) begin
            if (i > 0 || 1'b1) begin end
            if (busy === 1'b1 && i > 0) bcnt++;
            tick();
            if (done === 1'b1) begin
                dcnt++;
                got_d = diff;
                got_b = borrow_out;
            end
        end
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dcnt); end
        checks++; if (got_d !== 8'h7F) begin errors++; $display("FAIL ignore_diff: got %h expected 7f", got_d); end
        checks++; if (got_b !== 1'b0) begin errors++; $display("FAIL ignore_borrow: got %b expected 0", got_b); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second_op: busy got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h10, 8'h01, 8'hAA};
        logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h55};
        logic [7:0] ed [3] = '{8'h0F, 8'hF1, 8'h55};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        int k;
        int last;
        int cyc;
        k     = 0;
        last  = 0;
        cyc   = 0;
        a     = va[0];
        b     = vb[0];
        start = 1'b1;
        while (k < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                checks++; if (diff !== ed[k]) begin errors++; $display("FAIL b2b_diff[%0d]: got %h expected %h", k, diff, ed[k]); end
                checks++; if (borrow_out !== eb[k]) begin errors++; $display("FAIL b2b_borrow[%0d]: got %b expected %b", k, borrow_out, eb[k]); end
                if (k > 0) begin
                    checks++; if (cyc - last !== 10) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 10", k, cyc - last); end
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    a = va[k];
                    b = vb[k];
                end
            end
        end
        start = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_ops: got %0d expected 3", k); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int dcnt;
        int cyc;
        int bcnt;
        a     = 8'h05;
        b     = 8'h03;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL midrst_diff: got %h expected 00", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_borrow: got %b expected 0", borrow_out); end
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL midrst_no_activity: got %0d expected 0", dcnt); end
        run_op(8'h09, 8'h04, cyc, bcnt);
        checks++; if (cyc !== 8) begin errors++; $display("FAIL midrst_latency: got %0d expected 8", cyc); end
        checks++; if (diff !== 8'h05) begin errors++; $display("FAIL midrst_diff_after: got %h expected 05", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL midrst_borrow_after: got %b expected 0", borrow_out); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0]  ra8, rb8, e8;
        logic [0:0]  ra1, rb1, e1;
        logic [31:0] ra32, rb32, e32;
        logic        seen1, seen8, seen32;
        int          cyc;
        for (int n = 0; n < 1000; n++) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            ra1  = 1'($urandom);
            rb1  = 1'($urandom);
            ra32 = $urandom;
            rb32 = $urandom;
            if (n == 0) begin ra32 = 32'h0000_0000; rb32 = 32'hFFFF_FFFF; end
            if (n == 1) begin ra32 = 32'hFFFF_FFFF; rb32 = 32'h0000_0000; end
            e8   = ra8 - rb8;
            e1   = ra1 - rb1;
            e32  = ra32 - rb32;
            a = ra8;   b = rb8;   start = 1'b1;
            s1_a = ra1; s1_b = rb1; s1_start = 1'b1;
            s32_a = ra32; s32_b = rb32; s32_start = 1'b1;
            tick();
            start = 1'b0; s1_start = 1'b0; s32_start = 1'b0;
            seen1 = 1'b0; seen8 = 1'b0; seen32 = 1'b0;
            cyc   = 0;
            while (!(seen1 && seen8 && seen32) && cyc < 40) begin
                tick();
                cyc++;
                if (!seen1 && s1_done === 1'b1) begin
                    seen1 = 1'b1;
                    checks++; if (cyc !== 1) begin errors++; $display("FAIL rand_w1_latency[%0d]: got %0d expected 1", n, cyc); end
                    checks++; if (s1_diff !== e1 || s1_borrow !== (ra1 < rb1)) begin errors++; $display("FAIL rand_w1[%0d]: got %b/%b expected %b/%b", n, s1_diff, s1_borrow, e1, ra1 < rb1); end
                end
                if (!seen8 && done === 1'b1) begin
                    seen8 = 1'b1;
                    checks++; if (cyc !== 8) begin errors++; $display("FAIL rand_w8_latency[%0d]: got %0d expected 8", n, cyc); end
                    checks++; if (diff !== e8 || borrow_out !== (ra8 < rb8)) begin errors++; $display("FAIL rand_w8[%0d]: got %h/%b expected %h/%b", n, diff, borrow_out, e8, ra8 < rb8); end
                end
                if (!seen32 && s32_done === 1'b1) begin
                    seen32 = 1'b1;
                    checks++; if (cyc !== 32) begin errors++; $display("FAIL rand_w32_latency[%0d]: got %0d expected 32", n, cyc); end
                    checks++; if (s32_diff !== e32 || s32_borrow !== (ra32 < rb32)) begin errors++; $display("FAIL rand_w32[%0d]: got %h/%b expected %h/%b", n, s32_diff, s32_borrow, e32, ra32 < rb32); end
                end
            end
            checks++;
            if (!(seen1 && seen8 && seen32)) begin
                errors++;
                $display("FAIL rand_timeout[%0d]: done seen w1=%b w8=%b w32=%b expected all 1", n, seen1, seen8, seen32);
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        s1_start  = 1'b0;
        s1_a      = '0;
        s1_b      = '0;
        s32_start = 1'b0;
        s32_a     = '0;
        s32_b     = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
